// File: rtl/bcd_score_tracker.sv
// BCD score counter with saturation, a high score that survives clear, and
// active-low 7-segment display drive for NUM_DIGITS digits.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks HEX digits above the most
// significant non-zero digit of the displayed value (digit 0 always shown).
module bcd_score_tracker #(
   parameter int unsigned NUM_DIGITS = 4,
   parameter int unsigned EDGE_DET   = 1
) (
   input  logic                      Clock,
   input  logic                      Resetn,
   input  logic                      clear,
   input  logic                      score_event,
   input  logic [3:0]                points,
   input  logic                      show_high,
   output logic [4*NUM_DIGITS-1:0]   score_bcd,
   output logic [4*NUM_DIGITS-1:0]   high_bcd,
   output logic                      saturated,
   output logic                      new_high,
   output logic [7*NUM_DIGITS-1:0]   HEX
);

   localparam int unsigned W = 4 * NUM_DIGITS;

   logic [W-1:0] r_score;
   logic [W-1:0] r_high;
   logic         r_sat;
   logic         r_new_high;
   logic         r_event_q;

   logic         w_acc;
   logic [3:0]   w_pts;
   logic [W-1:0] w_sum;
   logic         w_carry_out;
   logic [W-1:0] w_sel;

   assign w_acc = (EDGE_DET != 0) ? (score_event & ~r_event_q) : score_event;
   assign w_pts = (points > 4'd9) ? 4'd9 : points;

   // Single-cycle decimal add with carry rippling through every digit
   always_comb begin : bcd_add
      logic [4:0] d;
      logic       c;
      w_sum       = '0;
      w_carry_out = 1'b0;
      c           = 1'b0;
      d           = '0;
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
         d = {1'b0, r_score[4*i +: 4]} + {4'b0000, c} + ((i == 0) ? {1'b0, w_pts} : 5'd0);
         if (d > 5'd9) begin
            d = d - 5'd10;
            c = 1'b1;
         end else begin
            c = 1'b0;
         end
         w_sum[4*i +: 4] = d[3:0];
      end
      w_carry_out = c;
   end

   // Live score, saturation flag and event edge register; clear drops any accept
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         r_score   <= '0;
         r_sat     <= 1'b0;
         r_event_q <= 1'b0;
      end else begin
         r_event_q <= score_event;
         if (clear) begin
            r_score <= '0;
            r_sat   <= 1'b0;
         end else if (w_acc) begin
            if (w_carry_out) begin
               r_score <= {NUM_DIGITS{4'h9}};
               r_sat   <= 1'b1;
            end else begin
               r_score <= w_sum;
            end
         end
      end
   end

   // High score trails the live score by one cycle; clear only resets the flag
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         r_high     <= '0;
         r_new_high <= 1'b0;
      end else begin
         if (r_score > r_high) begin
            r_high <= r_score;
         end
         if (clear) begin
            r_new_high <= 1'b0;
         end else if (r_score > r_high) begin
            r_new_high <= 1'b1;
         end
      end
   end

   assign score_bcd = r_score;
   assign high_bcd  = r_high;
   assign saturated = r_sat;
   assign new_high  = r_new_high;
   assign w_sel     = show_high ? r_high : r_score;

   function automatic logic [6:0] seg7(input logic [3:0] dig);
      logic [6:0] s;
      case (dig)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = 7'b1111111;
      endcase
      return s;
   endfunction

   // Per-digit segment decode of the selected value, with optional zero blanking
   always_comb begin : hex_decode
      logic upper_zero;
      HEX        = '1;
      upper_zero = 1'b1;
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
         HEX[7*i +: 7] = seg7(w_sel[4*i +: 4]);
      end
`ifdef LEADING_ZERO_BLANK_EN
      for (int i = int'(NUM_DIGITS) - 1; i >= 1; i--) begin
         upper_zero = upper_zero & (w_sel[4*i +: 4] == 4'd0);
         if (upper_zero) begin
            HEX[7*i +: 7] = 7'b1111111;
         end
      end
`else
      upper_zero = 1'b0;
`endif
   end

endmodule
